// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared IEEE-754 single-precision field constants, classes and helpers
package fp_pkg;

    localparam int FP32_EXP_BIAS = 127;
    localparam int FP32_FRAC_W   = 23;
    localparam int FP32_EXP_MAX  = 255;

    localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN = 32'h8000_0000;

    // m_axis_tuser bit positions
    localparam int TUSER_W       = 2;
    localparam int TUSER_SAT_BIT = 0;
    localparam int TUSER_INV_BIT = 1;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    // Unpacked float carried between conversion stages
    typedef struct packed {
        fp_class_e          cls;
        logic               sign;
        logic signed [8:0]  exp_unb;
        logic [23:0]        sig;
    } fp32_unpacked_t;

    // Denormals fold into FP_ZERO: they are far below integer resolution.
    function automatic fp_class_e fp32_classify(
        input logic [7:0]             exp_field,
        input logic [FP32_FRAC_W-1:0] frac_field
    );
        if (exp_field == 8'd0) begin
            return FP_ZERO;
        end else if (exp_field == 8'(FP32_EXP_MAX)) begin
            return (frac_field != '0) ? FP_NAN : FP_INF;
        end else begin
            return FP_NORM;
        end
    endfunction

endpackage

// File: rtl/axis_pipe_stage.sv
// rtl/axis_pipe_stage.sv - valid/ready register slice with WIDTH-bit payload
//
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_valid, i_data    upstream beat
//   o_ready            slice can take a beat (empty, or downstream accepting)
//   o_valid, o_data    registered beat to downstream
//   i_ready            downstream accepts
module axis_pipe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Advance when empty or when the held beat is leaving this cycle
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/float_to_int_axi.sv
// rtl/float_to_int_axi.sv - AXI4-Stream IEEE-754 single to int32 converter, 2-stage pipeline
//
// Optional macro FLOAT_TO_INT_ROUND_NEAREST_EN: round half to even instead of truncating.
//
// Ports:
//   aclk, areset                clock, asynchronous active-high reset
//   s_axis_tdata/tvalid/tready  float input stream
//   m_axis_tdata/tvalid/tready  int32 output stream
//   m_axis_tuser                [0] saturated, [1] invalid (NaN)
module float_to_int_axi
    import fp_pkg::*;
#(
    parameter logic [31:0] NAN_VALUE = 32'h0000_0000
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic [31:0]  s_axis_tdata,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    output logic [31:0]  m_axis_tdata,
    output logic [1:0]   m_axis_tuser,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready
);

    localparam int S1_W = $bits(fp32_unpacked_t);
    localparam int S2_W = 32 + TUSER_W;

    // ---------------- stage 1: unpack and classify ----------------
    fp32_unpacked_t    w_s1_in;
    fp32_unpacked_t    w_s1;
    logic [S1_W-1:0]   w_s1_q;
    logic              w_s1_valid;
    logic              w_s2_ready;

    always_comb begin
        w_s1_in.sign    = s_axis_tdata[31];
        w_s1_in.cls     = fp32_classify(s_axis_tdata[30:23], s_axis_tdata[FP32_FRAC_W-1:0]);
        w_s1_in.exp_unb = $signed({1'b0, s_axis_tdata[30:23]}) - 9'(FP32_EXP_BIAS);
        w_s1_in.sig     = {1'b1, s_axis_tdata[FP32_FRAC_W-1:0]};
    end

    axis_pipe_stage #(.WIDTH(S1_W)) u_stage1 (
        .i_clk   (aclk),
        .i_rst   (areset),
        .i_valid (s_axis_tvalid),
        .o_ready (s_axis_tready),
        .i_data  (w_s1_in),
        .o_valid (w_s1_valid),
        .o_data  (w_s1_q),
        .i_ready (w_s2_ready)
    );

    assign w_s1 = fp32_unpacked_t'(w_s1_q);

    // ---------------- stage 2: shift, round, negate, saturate ----------------
    logic signed [8:0] w_e;
    logic [4:0]        w_sh_l;
    logic [4:0]        w_sh_r;
    logic [31:0]       w_mag;
    logic [31:0]       w_result;
    logic [1:0]        w_tuser;
    logic [S2_W-1:0]   w_s2_q;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
    logic              w_guard;
    logic              w_sticky;
    logic [23:0]       w_low_mask;
`endif

    assign w_e = w_s1.exp_unb;

    always_comb begin
        w_sh_l   = '0;
        w_sh_r   = '0;
        w_mag    = '0;
        w_result = '0;
        w_tuser  = '0;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
        w_guard    = 1'b0;
        w_sticky   = 1'b0;
        w_low_mask = '0;
`endif
        case (w_s1.cls)
            FP_ZERO: begin
                w_result = '0;
            end
            FP_NAN: begin
                w_result               = NAN_VALUE;
                w_tuser[TUSER_INV_BIT] = 1'b1;
            end
            FP_INF: begin
                w_result               = w_s1.sign ? INT32_MIN : INT32_MAX;
                w_tuser[TUSER_SAT_BIT] = 1'b1;
            end
            default: begin
                if (w_e >= 9'sd31) begin
                    // -2^31 is the one E=31 value that is representable
                    if (w_s1.sign && (w_e == 9'sd31) && (w_s1.sig == 24'h80_0000)) begin
                        w_result = INT32_MIN;
                    end else begin
                        w_result               = w_s1.sign ? INT32_MIN : INT32_MAX;
                        w_tuser[TUSER_SAT_BIT] = 1'b1;
                    end
                end else begin
                    if (w_e >= 9'sd23) begin
                        w_sh_l = w_e[4:0] - 5'd23;
                        w_mag  = {8'd0, w_s1.sig} << w_sh_l;
                    end else if (w_e >= 9'sd0) begin
                        w_sh_r = 5'd23 - w_e[4:0];
                        w_mag  = {8'd0, w_s1.sig >> w_sh_r};
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
                        // guard = first discarded bit, sticky = OR of the rest
                        w_low_mask = (24'd1 << (w_sh_r - 5'd1)) - 24'd1;
                        w_guard    = |(w_s1.sig & (24'd1 << (w_sh_r - 5'd1)));
                        w_sticky   = |(w_s1.sig & w_low_mask);
`endif
                    end else begin
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
                        // [0.5,1): the hidden one is the guard bit
                        if (w_e == -9'sd1) begin
                            w_guard  = 1'b1;
                            w_sticky = |w_s1.sig[22:0];
                        end
`endif
                    end
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
                    // Magnitude is below 2^23 whenever guard is set, so no overflow
                    if (w_guard && (w_sticky || w_mag[0])) begin
                        w_mag = w_mag + 32'd1;
                    end
`endif
                    w_result = w_s1.sign ? (~w_mag + 32'd1) : w_mag;
                end
            end
        endcase
    end

    axis_pipe_stage #(.WIDTH(S2_W)) u_stage2 (
        .i_clk   (aclk),
        .i_rst   (areset),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_ready),
        .i_data  ({w_tuser, w_result}),
        .o_valid (m_axis_tvalid),
        .o_data  (w_s2_q),
        .i_ready (m_axis_tready)
    );

    assign m_axis_tdata = w_s2_q[31:0];
    assign m_axis_tuser = w_s2_q[S2_W-1:32];

endmodule

// File: tb/tb_float_to_int_axi.sv
// tb/tb_float_to_int_axi.sv - directed self-checking bench for float_to_int_axi
module tb_float_to_int_axi;

    localparam logic [31:0] TB_NAN = 32'h7FC0_0001;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        aclk;
    logic        areset;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [1:0]  m_tuser;
    logic        m_tvalid;
    logic        m_tready;

    int checks = 0;
    int errors = 0;

    float_to_int_axi #(.NAN_VALUE(TB_NAN)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One beat through an unstalled pipe; output must appear in the 2nd cycle after the handshake
    task automatic convert(input string tag, input logic [31:0] f,
                           input logic [31:0] exp_d, input logic [1:0] exp_u);
        @(negedge aclk);
        m_tready = 1'b1;
        s_tdata  = f;
        s_tvalid = 1'b1;
        #1;
        chk1({tag, "/s_tready"}, s_tready, 1'b1);
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        @(negedge aclk);
        chk1({tag, "/early"}, m_tvalid, 1'b0);
        @(negedge aclk);
        chk1({tag, "/valid"}, m_tvalid, 1'b1);
        chk32({tag, "/data"}, m_tdata, exp_d);
        chk2({tag, "/user"}, m_tuser, exp_u);
    endtask

    logic [31:0] bp_in [8] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                               32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
    int          sent;
    int          got;
    int          stall_left;
    int          stall_pos;
    bit          stall_started;
    bit          do_in;
    logic [31:0] held;

    initial begin
        areset   = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;

        // reset state
        #3;
        chk1("rst/m_tvalid", m_tvalid, 1'b0);
        chk32("rst/m_tdata", m_tdata, 32'h0);
        chk2("rst/m_tuser", m_tuser, 2'b00);
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk);
        #1;
        chk1("rst/s_tready", s_tready, 1'b1);

        // basic values
        convert("one",      32'h3F80_0000, 32'h0000_0001, 2'b00);
        convert("m123_456", 32'hC2F6_E979, 32'hFFFF_FF85, 2'b00);
        convert("m1",       32'hBF80_0000, 32'hFFFF_FFFF, 2'b00);
        convert("e23",      32'h4B00_0001, 32'h0080_0001, 2'b00);
        convert("e30max",   32'h4EFF_FFFF, 32'h7FFF_FF80, 2'b00);

        // range edges
        convert("p2_31",    32'h4F00_0000, 32'h7FFF_FFFF, 2'b01);
        convert("m2_31",    32'hCF00_0000, 32'h8000_0000, 2'b00);
        convert("m2_31up",  32'hCF00_0001, 32'h8000_0000, 2'b01);
        convert("negzero",  32'h8000_0000, 32'h0000_0000, 2'b00);
        convert("denorm",   32'h0000_0001, 32'h0000_0000, 2'b00);

        // specials
        convert("qnan",     32'h7FC0_0000, TB_NAN,        2'b10);
        convert("negnan",   32'hFF80_0001, TB_NAN,        2'b10);
        convert("pinf",     32'h7F80_0000, 32'h7FFF_FFFF, 2'b01);
        convert("ninf",     32'hFF80_0000, 32'h8000_0000, 2'b01);

        // rounding
        convert("r1_5",     32'h3FC0_0000, RNE ? 32'h2 : 32'h1, 2'b00);
        convert("r2_5",     32'h4020_0000, 32'h2, 2'b00);
        convert("r2_75",    32'h4030_0000, RNE ? 32'h3 : 32'h2, 2'b00);
        convert("r5_5",     32'h40B0_0000, RNE ? 32'h6 : 32'h5, 2'b00);
        convert("rm0_75",   32'hBF40_0000, RNE ? 32'hFFFF_FFFF : 32'h0, 2'b00);
        convert("r0_5",     32'h3F00_0000, 32'h0, 2'b00);
        convert("r0_999",   32'h3F7F_FFFF, RNE ? 32'h1 : 32'h0, 2'b00);
        convert("r0_25",    32'h3E80_0000, 32'h0, 2'b00);
        convert("r_e22",    32'h4AFF_FFFF, RNE ? 32'h0080_0000 : 32'h007F_FFFF, 2'b00);

        // backpressure: 8 back-to-back beats, 4-cycle stall after 2nd output
        sent          = 0;
        got           = 0;
        stall_left    = 0;
        stall_started = 1'b0;
        held          = '0;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            @(negedge aclk);
            if (got >= 2 && !stall_started) begin
                stall_started = 1'b1;
                stall_left    = 4;
            end
            m_tready = (stall_left == 0);
            s_tvalid = (sent < 8);
            s_tdata  = (sent < 8) ? bp_in[sent] : 32'h0;
            #1;
            if (stall_left > 0) begin
                stall_pos = 4 - stall_left;
                chk1("bp/stall_valid", m_tvalid, 1'b1);
                if (stall_pos >= 1) begin
                    chk1("bp/s_tready_low", s_tready, 1'b0);
                    chk32("bp/stable", m_tdata, held);
                end else begin
                    held = m_tdata;
                end
                stall_left--;
            end
            do_in = s_tvalid && s_tready;
            if (m_tvalid && m_tready) begin
                chk32("bp/order", m_tdata, 32'(got + 1));
                chk2("bp/user", m_tuser, 2'b00);
                got++;
            end
            @(posedge aclk);
            #1;
            if (do_in) sent++;
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        chk32("bp/sent", 32'(sent), 32'd8);
        chk32("bp/got", 32'(got), 32'd8);
        chk1("bp/stalled", stall_started, 1'b1);
        @(negedge aclk);
        chk1("bp/no_dup", m_tvalid, 1'b0);

        // reset mid-stream with both stages full
        @(negedge aclk);
        m_tready = 1'b0;
        s_tdata  = 32'h4040_0000;
        s_tvalid = 1'b1;
        @(negedge aclk);
        s_tdata  = 32'h4080_0000;
        @(negedge aclk);
        s_tvalid = 1'b0;
        chk1("mid/full_valid", m_tvalid, 1'b1);
        chk1("mid/full_ready", s_tready, 1'b0);
        #2;
        areset = 1'b1;
        #1;
        chk1("mid/async_valid", m_tvalid, 1'b0);
        chk1("mid/async_ready", s_tready, 1'b1);
        chk32("mid/async_data", m_tdata, 32'h0);
        @(negedge aclk);
        areset   = 1'b0;
        m_tready = 1'b1;
        @(negedge aclk);
        chk1("mid/drop", m_tvalid, 1'b0);
        @(negedge aclk);
        chk1("mid/drop2", m_tvalid, 1'b0);
        convert("mid/ten", 32'h4120_0000, 32'h0000_000A, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/float_to_int_axi.md
Name: float_to_int_axi

Overview:
- Converts IEEE-754 single-precision values to 32-bit two's-complement integers.
- Inverse of the team's int-to-float converter: int_to_float_axi produces the floats, this block consumes them and returns integers to the fixed-point datapath.
- Full AXI4-Stream slave input and master output, with backpressure.
- 2-stage pipeline; throughput 1 beat/cycle.

Parameters:
- NAN_VALUE, 32'h0000_0000, integer emitted for NaN inputs.

Ports:
- aclk  input  1  clock; all logic on rising edge.
- areset  input  1  asynchronous, active-high reset.
- s_axis_tdata  input  32  float in: sign[31], exp[30:23], frac[22:0].
- s_axis_tvalid  input  1  input beat valid.
- s_axis_tready  output  1  block can accept a beat.
- m_axis_tdata  output  32  integer result.
- m_axis_tuser  output  2  [0] saturated (out of range or inf), [1] invalid (NaN).
- m_axis_tvalid  output  1  output beat valid.
- m_axis_tready  input  1  downstream accepts.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - areset asserted clears both stage valid flags immediately.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0.
  - s_axis_tready=1 from the first edge after release.
  - In-flight beats are dropped when reset is asserted mid-stream.
- Handshake:
  - A transfer occurs on any edge where tvalid && tready.
  - Once m_axis_tvalid is high, m_axis_tdata and m_axis_tuser stay stable until accepted.
- Pipeline:
  - Stage 1 registers unpack and classify: zero/denormal, normal, inf, NaN; unbiased exponent E=exp-127; 24-bit significand {1,frac}.
  - Stage 2 registers shift, round, negate and saturate; it drives the m_axis outputs.
  - Each stage advances when it is empty or the stage after it is accepting.
  - s_axis_tready = !v1 || (!v2 || m_axis_tready). It is combinational from m_axis_tready; this is the only allowed comb path.
  - Latency: 2 cycles from input handshake to m_axis_tvalid when unstalled.
  - Sustained back-to-back beats give one output per cycle.
  - Under stall, at most 2 beats are held, with no loss or duplication and order preserved.
- Arithmetic:
  - exp==0: result 0, flags 0. Denormals and ±0 both map here, so -0 gives 0.
  - exp==255, frac!=0: result NAN_VALUE, tuser=2'b10.
  - exp==255, frac==0: +inf gives 32'h7FFF_FFFF, -inf gives 32'h8000_0000; tuser=2'b01.
  - E>=31: saturate as for inf, tuser=2'b01. Exception: the exact value -2^31 (32'hCF00_0000) gives 32'h8000_0000 with tuser=0.
  - 23<=E<=30: magnitude = significand << (E-23).
  - 0<=E<23: magnitude = significand >> (23-E). Discarded bits feed the rounding logic.
  - E<0: magnitude 0 in default mode.
  - Negative sign: result = two's complement of magnitude.
  - Default rounding: toward zero (truncate).
  - Rounding can never overflow, because float spacing near 2^31 is 128.

Optional Feature:
- Macro: FLOAT_TO_INT_ROUND_NEAREST_EN.
- Defined: round half to even, using guard and sticky bits from the right shift.
  - E=-1 (values in [0.5,1)) rounds to 1 when above 0.5 and to 0 at exactly 0.5.
  - E<-1 gives 0.
  - Rounding is applied to the magnitude before negation.
- Undefined: truncation; guard/sticky logic is not synthesized.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package fp_pkg:
  - Field constants: FP32_EXP_BIAS=127, FP32_FRAC_W=23, FP32_EXP_MAX=255, INT32_MAX, INT32_MIN.
  - Class enum: FP_ZERO, FP_NORM, FP_INF, FP_NAN.
  - tuser bit indices.
  - The existing int-to-float block also moves onto fp_pkg.
- One sub-module, axis_pipe_stage: a valid/ready register slice with payload parameter WIDTH, instantiated twice.
- Conversion logic stays in the top level.

Test Plan:
- Basic values, m_axis_tready=1:
  - 32'h3F80_0000 -> 32'h0000_0001, tuser 0, m_axis_tvalid exactly 2 cycles after the handshake.
  - 32'hC2F6_E979 (-123.456) -> 32'hFFFF_FF85.
- Range edges:
  - 32'h4F00_0000 -> 32'h7FFF_FFFF, tuser 01.
  - 32'hCF00_0000 -> 32'h8000_0000, tuser 00.
  - 32'h8000_0000 -> 0.
  - 32'h0000_0001 (denormal) -> 0.
- Specials:
  - 32'h7FC0_0000 -> NAN_VALUE, tuser 10.
  - 32'h7F80_0000 -> 32'h7FFF_FFFF, tuser 01.
  - 32'hFF80_0000 -> 32'h8000_0000, tuser 01.
- Backpressure: 8 back-to-back beats (1.0 to 8.0), m_axis_tready low for 4 cycles after the 2nd output.
  - s_axis_tready falls within 1 cycle.
  - Outputs are 1..8 in order, none lost or duplicated, data stable while stalled.
- Reset mid-stream: assert areset with both stages valid.
  - m_axis_tvalid drops with no clock edge.
  - After release, a fresh beat 32'h4120_0000 -> 32'h0000_000A.
- Rounding, both builds:
  - 32'h3FC0_0000 (1.5) -> 1 truncating, 2 RNE.
  - 32'h4020_0000 (2.5) -> 2 in both.
  - 32'hBF40_0000 (-0.75) -> 0 truncating, 32'hFFFF_FFFF RNE.
  - 32'h3F00_0000 (0.5) -> 0 in both.
